// File: rtl/rob_mp_pkg.sv
// rtl/rob_mp_pkg.sv - shared sizes and entry types for the multi-port reorder buffer
package rob_mp_pkg;

  localparam int NR_ROB_ENTRIES  = 16;
  localparam int NR_WB_PORTS     = 2;
  localparam int NR_COMMIT_PORTS = 2;
  localparam int ROB_IDW         = $clog2(NR_ROB_ENTRIES);

  typedef logic [ROB_IDW-1:0] rob_id_t;

  typedef struct packed {
    rob_id_t     id;
    logic [31:0] pc;
    logic [5:0]  prd;
    logic [4:0]  ard;
    logic        needprf2arf;
    logic        completed;
  } rob_entry_t;

endpackage

// File: rtl/rob_mp_onehot_prefix_cnt.sv
// rtl/rob_mp_onehot_prefix_cnt.sv - counts the fired lanes contiguous from lane 0
module onehot_prefix_cnt #(
  parameter int N  = 2,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  fire_i,
  output logic [CW-1:0] cnt_o
);

  // A lane only counts while every lower lane has fired as well.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < N; i++) begin
      if (fire_i[i] && (cnt_o == CW'(i))) begin
        cnt_o = cnt_o + CW'(1);
      end
    end
  end

endmodule

// File: rtl/rob_mp.sv
// rtl/rob_mp.sv - multi-port reorder buffer: in-order alloc, out-of-order completion, in-order retire
// Optional feature macro: ROB_FLUSH_EN (flush_i discards all entries when defined).
module rob_mp
  import rob_mp_pkg::*;
#(
  parameter int DEPTH     = NR_ROB_ENTRIES,
  parameter int NR_PUSH   = 2,
  parameter int NR_WB     = NR_WB_PORTS,
  parameter int NR_COMMIT = NR_COMMIT_PORTS,
  parameter int IDW       = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NR_PUSH-1:0]               push_valid_i,
  output logic [NR_PUSH-1:0]               push_ready_o,
  input  rob_entry_t [NR_PUSH-1:0]         push_data_i,
  output logic [NR_PUSH-1:0][IDW-1:0]      push_id_o,
  input  logic [NR_WB-1:0]                 wb_valid_i,
  input  logic [NR_WB-1:0][IDW-1:0]        wb_id_i,
  output logic [NR_COMMIT-1:0]             commit_valid_o,
  input  logic [NR_COMMIT-1:0]             commit_ready_i,
  output rob_entry_t [NR_COMMIT-1:0]       commit_data_o,
  output logic [IDW:0]                     count_o,
  output logic                             full_o,
  output logic                             empty_o,
  input  logic                             flush_i
);

  localparam int PCW = $clog2(NR_PUSH + 1);
  localparam int CCW = $clog2(NR_COMMIT + 1);
  localparam logic [IDW:0] DEPTH_C = (IDW + 1)'(DEPTH);

  rob_entry_t          entry_q [DEPTH];
  rob_entry_t          entry_d [DEPTH];
  logic [DEPTH-1:0]    alloc_q, alloc_d, done_q, done_d;
  logic [IDW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [IDW:0]        count_q, count_d, free_cnt;
  logic [NR_PUSH-1:0]  push_fire;
  logic [NR_COMMIT-1:0] commit_fire;
  logic [PCW-1:0]      push_cnt;
  logic [CCW-1:0]      commit_cnt;

  assign free_cnt = DEPTH_C - count_q;
  assign count_o  = count_q;
  assign full_o   = (count_q == DEPTH_C);
  assign empty_o  = (count_q == '0);

  always_comb begin
    for (int i = 0; i < NR_PUSH; i++) begin
      push_ready_o[i] = (free_cnt > (IDW + 1)'(i));
      push_id_o[i]    = tail_q + IDW'(i);
    end
  end

  assign push_fire = push_valid_i & push_ready_o;

  // Retire window depends on registered state only, so no input reaches it combinationally.
  always_comb begin
    logic           run;
    logic [IDW-1:0] idx;
    run = 1'b1;
    idx = '0;
    for (int k = 0; k < NR_COMMIT; k++) begin
      idx = head_q + IDW'(k);
      run = run & alloc_q[idx] & done_q[idx] & (count_q > (IDW + 1)'(k));
      commit_valid_o[k]           = run;
      commit_data_o[k]            = entry_q[idx];
      commit_data_o[k].completed  = done_q[idx];
    end
  end

  assign commit_fire = commit_valid_o & commit_ready_i;

  onehot_prefix_cnt #(.N(NR_PUSH), .CW(PCW)) u_push_cnt (
    .fire_i (push_fire),
    .cnt_o  (push_cnt)
  );

  onehot_prefix_cnt #(.N(NR_COMMIT), .CW(CCW)) u_commit_cnt (
    .fire_i (commit_fire),
    .cnt_o  (commit_cnt)
  );

  // Writeback first, then retire clears, then allocation: a slot freed and reused this cycle ends up freshly allocated.
  always_comb begin
    logic [IDW-1:0] idx;
    idx     = '0;
    entry_d = entry_q;
    alloc_d = alloc_q;
    done_d  = done_q;
    head_d  = head_q + IDW'(commit_cnt);
    tail_d  = tail_q + IDW'(push_cnt);
    count_d = count_q + (IDW + 1)'(push_cnt) - (IDW + 1)'(commit_cnt);
    for (int w = 0; w < NR_WB; w++) begin
      if (wb_valid_i[w] && alloc_q[wb_id_i[w]]) begin
        done_d[wb_id_i[w]] = 1'b1;
      end
    end
    for (int k = 0; k < NR_COMMIT; k++) begin
      idx = head_q + IDW'(k);
      if (CCW'(k) < commit_cnt) begin
        alloc_d[idx] = 1'b0;
        done_d[idx]  = 1'b0;
      end
    end
    for (int i = 0; i < NR_PUSH; i++) begin
      idx = tail_q + IDW'(i);
      if (PCW'(i) < push_cnt) begin
        entry_d[idx]           = push_data_i[i];
        entry_d[idx].completed = 1'b0;
        alloc_d[idx]           = 1'b1;
        done_d[idx]            = 1'b0;
      end
    end
`ifdef ROB_FLUSH_EN
    if (flush_i) begin
      alloc_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
`endif
  end

`ifndef ROB_FLUSH_EN
  logic unused_flush;
  assign unused_flush = flush_i;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      alloc_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      alloc_q <= alloc_d;
      done_q  <= done_d;
    end
  end

  // Payload storage is qualified by alloc_q, so it carries no reset.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  a_push_contig: assert property (@(posedge clk) disable iff (rst)
    ((push_valid_i & (push_valid_i + NR_PUSH'(1))) == '0));

  for (genvar w = 0; w < NR_WB; w++) begin : g_wb_chk
    a_wb_alloc: assert property (@(posedge clk) disable iff (rst)
      (wb_valid_i[w] |-> alloc_q[wb_id_i[w]]));
  end

endmodule

// File: tb/tb_rob_mp.sv
// tb/tb_rob_mp.sv - directed and random checks of rob_mp against a queue-based in-order model
module tb_rob_mp;
  import rob_mp_pkg::*;

  localparam int D = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [1:0]          push_valid_i, push_ready_o, wb_valid_i, commit_valid_o, commit_ready_i;
  rob_entry_t [1:0]    push_data_i, commit_data_o;
  logic [1:0][3:0]     push_id_o, wb_id_i;
  logic [4:0]          count_o;
  logic                full_o, empty_o, flush_i;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0] id;
    rob_entry_t data;
    bit         done;
  } mdl_t;

  mdl_t q[$];
  int   tail_m = 0;

  rob_mp dut (
    .clk(clk), .rst(rst),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_data_i(push_data_i), .push_id_o(push_id_o),
    .wb_valid_i(wb_valid_i), .wb_id_i(wb_id_i),
    .commit_valid_o(commit_valid_o), .commit_ready_i(commit_ready_i),
    .commit_data_o(commit_data_o),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
    .flush_i(flush_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic rob_entry_t rand_entry(input int id);
    rob_entry_t e;
    e.id          = 4'(id);
    e.pc          = $urandom;
    e.prd         = 6'($urandom);
    e.ard         = 5'($urandom);
    e.needprf2arf = 1'($urandom);
    e.completed   = 1'($urandom);
    return e;
  endfunction

  task automatic clear_inputs();
    push_valid_i   = '0;
    push_data_i    = '0;
    wb_valid_i     = '0;
    wb_id_i        = '0;
    commit_ready_i = '0;
    flush_i        = 1'b0;
  endtask

  task automatic set_push(input int n);
    push_valid_i = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
    for (int i = 0; i < 2; i++) push_data_i[i] = rand_entry((tail_m + i) % D);
  endtask

  task automatic set_commit(input int n);
    commit_ready_i = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
  endtask

  task automatic model_reset();
    q.delete();
    tail_m = 0;
  endtask

  task automatic check_outputs();
    int         sz;
    bit         run;
    rob_entry_t e;
    sz  = q.size();
    run = 1'b1;
    chk("count", 64'(count_o), 64'(sz));
    chk("full", 64'(full_o), 64'(sz == D));
    chk("empty", 64'(empty_o), 64'(sz == 0));
    for (int i = 0; i < 2; i++) begin
      chk("push_ready", 64'(push_ready_o[i]), 64'((D - sz) > i));
      chk("push_id", 64'(push_id_o[i]), 64'((tail_m + i) % D));
    end
    for (int k = 0; k < 2; k++) begin
      run = run && (k < sz) && q[k].done;
      chk("commit_valid", 64'(commit_valid_o[k]), 64'(run));
      if (run) begin
        e = q[k].data;
        e.completed = 1'b1;
        chk("commit_data", 64'(commit_data_o[k]), 64'(e));
      end
    end
  endtask

  task automatic update_model();
    int  sz, nc, np;
    bit  run;
    sz = q.size();
    nc = 0;
    np = 0;
`ifdef ROB_FLUSH_EN
    if (flush_i) begin
      model_reset();
      return;
    end
`endif
    run = 1'b1;
    for (int k = 0; k < 2; k++) begin
      run = run && (k < sz) && q[k].done;
      if (run && commit_ready_i[k] && nc == k) nc++;
    end
    for (int i = 0; i < 2; i++)
      if (push_valid_i[i] && (D - sz) > i && np == i) np++;
    for (int w = 0; w < 2; w++)
      if (wb_valid_i[w])
        for (int j = 0; j < q.size(); j++)
          if (q[j].id == wb_id_i[w]) q[j].done = 1'b1;
    repeat (nc) void'(q.pop_front());
    for (int i = 0; i < np; i++) begin
      q.push_back('{id: 4'(tail_m), data: push_data_i[i], done: 1'b0});
      tail_m = (tail_m + 1) % D;
    end
  endtask

  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset mid-run with five entries held
    set_push(2); cycle();
    set_push(2); cycle();
    set_push(1); cycle();
    clear_inputs();
    #1;
    chk("count_before_reset", 64'(count_o), 64'd5);
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    chk("reset_push_id", 64'(push_id_o), 64'h10);
    chk("reset_ready", 64'(push_ready_o), 64'h3);
    @(negedge clk);
    rst = 1'b0;

    // fill to full with no completions
    for (int c = 0; c < 8; c++) begin
      set_push(2);
      cycle();
    end
    clear_inputs();
    #1;
    chk("full_after_fill", 64'(full_o), 64'd1);
    chk("ready_at_full", 64'(push_ready_o), 64'd0);

    // out-of-order completion: id 1 then id 0
    wb_valid_i = 2'b01; wb_id_i[0] = 4'd1;
    cycle();
    clear_inputs();
    #1;
    chk("cv_after_wb1", 64'(commit_valid_o), 64'd0);
    wb_valid_i = 2'b01; wb_id_i[0] = 4'd0;
    cycle();
    clear_inputs();
    #1;
    chk("cv_after_wb0", 64'(commit_valid_o), 64'h3);
    set_commit(2);
    set_push(2);
    cycle();
    clear_inputs();
    #1;
    chk("count_after_commit", 64'(count_o), 64'd14);

    // simultaneous retire and wrapped allocation
    wb_valid_i = 2'b11; wb_id_i[0] = 4'd2; wb_id_i[1] = 4'd3;
    cycle();
    clear_inputs();
    set_commit(2);
    set_push(2);
    #1;
    chk("wrap_ids", 64'(push_id_o), 64'h10);
    cycle();
    clear_inputs();
    #1;
    chk("count_steady", 64'(count_o), 64'd14);
    wb_valid_i = 2'b11; wb_id_i[0] = 4'd4; wb_id_i[1] = 4'd4;
    cycle();
    clear_inputs();
    #1;
    chk("head_moved", 64'(commit_data_o[0].id), 64'd4);
    set_push(2);
    cycle();
    clear_inputs();
    #1;
    chk("refull", 64'(full_o), 64'd1);

    // randomized traffic
    repeat (400) begin
      clear_inputs();
      set_push($urandom_range(2));
      set_commit($urandom_range(2));
      for (int w = 0; w < 2; w++) begin
        if (q.size() > 0 && $urandom_range(1) == 1) begin
          wb_valid_i[w] = 1'b1;
          wb_id_i[w]    = q[$urandom_range(q.size() - 1)].id;
        end
      end
      cycle();
    end
    clear_inputs();

`ifdef ROB_FLUSH_EN
    do_reset();
    set_push(2); cycle();
    set_push(2); cycle();
    set_push(2); cycle();
    set_push(1); cycle();
    clear_inputs();
    flush_i = 1'b1;
    set_push(2);
    wb_valid_i = 2'b01; wb_id_i[0] = 4'd3;
    cycle();
    clear_inputs();
    #1;
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_push_id0", 64'(push_id_o[0]), 64'd0);
    set_push(2); cycle();
    set_push(2); cycle();
    clear_inputs();
    #1;
    chk("flush_wb_dropped", 64'(commit_valid_o), 64'd0);
`else
    do_reset();
    flush_i = 1'b1;
    set_push(2);
    cycle();
    clear_inputs();
    #1;
    chk("flush_ignored", 64'(count_o), 64'd2);
`endif
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
